fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Parametrised instruction fetch queue between Instruction_Memory and decode.
//   Owns the fetch PC, issues one sequential fetch per cycle and buffers up to DEPTH fetched
//   {instr, pc, pc+4} entries, so decode stalls (StallD) no longer freeze fetch.
//   A taken branch/jump (PCSrc) flushes the queue and redirects the PC.
//   Generalises the fixed next_pc + reg1 pair: it has depth, occupancy tracking and
//   redirect/stall arbitration.
// PARAMETERS
//   XLEN     32            address/PC width; must be >= 3
//   DEPTH    4             queue entries; power of two, >= 2
//   RESET_PC 32'h00000000  fetch PC after reset (XLEN bits)
//   NOP      32'h00000013  instruction presented when queue empty (addi x0,x0,0)
// PORTS
//   clk          in   1          clock; all state updates on rising edge
//   reset        in   1          synchronous, active-low reset
//   fetch_en     in   1          1 = allowed to fetch this cycle
//   redirect     in   1          PCSrc from EX; flush + redirect
//   redirect_pc  in   XLEN       PCTarget; used only when redirect=1
//   imem_addr    out  XLEN       fetch address to Instruction_Memory (= pc_q)
//   imem_rdata   in   32         instruction at imem_addr; combinational, same cycle
//   dec_stall    in   1          decode not accepting (StallD)
//   dec_valid    out  1          head entry valid
//   dec_instr    out  32         head instruction; NOP when empty
//   dec_pc       out  XLEN       head PC; 0 when empty
//   dec_pcplus4  out  XLEN       head PC+4; 0 when empty
//   count        out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   full         out  1          count == DEPTH
//   empty        out  1          count == 0
// BEHAVIOUR
// - Reset (reset==0 at edge): pc_q=RESET_PC, rd_ptr=wr_ptr=0, count=0.
//   Outputs then: dec_valid=0, dec_instr=NOP, full=0, empty=1.
//   Reset beats every other input.
// - imem_addr = pc_q, combinational, always driven.
// - pop  = dec_valid & ~dec_stall.
// - push = fetch_en & ~redirect & (~full | pop).
//   Push at full is legal only with a simultaneous pop.
// - Push: the entry {imem_rdata, pc_q, pc_q+4} is written at wr_ptr.
//   Then wr_ptr++ and pc_q <= pc_q+4.
// - No push and no redirect: pc_q holds.
// - Pop: rd_ptr++.
// - Count update: push&~pop -> +1; pop&~push -> -1; both or neither -> hold.
// - Pointers wrap modulo DEPTH; PC arithmetic wraps modulo 2^XLEN (no carry kept).
// - Show-ahead: dec_* are driven combinationally from the entry at rd_ptr.
//   Latency from fetch to dec_valid is 1 cycle.
// - Redirect has priority over push and pop at the same edge:
//   - count=0, rd_ptr=wr_ptr=0, pc_q=redirect_pc;
//   - the current imem_rdata and the current head are discarded.
// - Redirect while empty or full: same result (queue empty, PC redirected).
// - fetch_en=0: no push; pops continue, so the queue drains.
// - redirect_pc[1:0] != 0: taken as-is, no alignment trap (checked elsewhere).
// - Storage contents are don't-care outside valid entries; no X is observable on dec_*.
// TESTING
// 1. Reset: reset=0 for 2 cycles, then release.
//    -> imem_addr=RESET_PC, empty=1, dec_instr=32'h13, dec_valid=0.
// 2. Fill: fetch_en=1, dec_stall=1 for 6 cycles (DEPTH=4).
//    -> count 1,2,3,4,4,4; full=1; imem_addr stops at 0x10.
//    -> head pc=0x0, dec_pcplus4=0x4.
// 3. Drain/throughput: from full, dec_stall=0, fetch_en=1.
//    -> one pop and one push per cycle; count stays 4.
//    -> dec_pc steps 0x0,0x4,0x8,... with no bubbles.
// 4. Redirect while full, with dec_stall=0 and redirect_pc=0x100.
//    -> next cycle count=0, imem_addr=0x100, dec_valid=0.
//    -> the cycle after: dec_pc=0x100, count=1.
// 5. Wrap: XLEN=32, pc_q=0xFFFFFFFC, push.
//    -> entry dec_pcplus4=0x0, next imem_addr=0x0.
//    -> 10 push/pop cycles wrap pointers with FIFO order preserved.
// 6. Reset mid-operation: count=3, then reset=0 while redirect=1 and fetch_en=1.
//    -> count=0, imem_addr=RESET_PC (not redirect_pc).

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch/decode handshake bundle for fetch_queue.
//   Fetch side:  fetch_en, redirect, redirect_pc (to queue); imem_addr (from queue),
//                imem_rdata (to queue, combinational instruction at imem_addr).
//   Decode side: dec_stall (to queue); dec_valid, dec_instr, dec_pc, dec_pcplus4,
//                count, full, empty (from queue).
//   slave  modport: the fetch queue itself.
//   master modport: the surrounding pipeline / memory that drives it.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            fetch_en;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            dec_stall;
    logic            dec_valid;
    logic [31:0]     dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pcplus4;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    modport slave (
        input  fetch_en, redirect, redirect_pc, imem_rdata, dec_stall,
        output imem_addr, dec_valid, dec_instr, dec_pc, dec_pcplus4, count, full, empty
    );

    modport master (
        output fetch_en, redirect, redirect_pc, imem_rdata, dec_stall,
        input  imem_addr, dec_valid, dec_instr, dec_pc, dec_pcplus4, count, full, empty
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between instruction memory and decode.
//   Owns the fetch PC, fetches one sequential instruction per cycle and buffers up
//   to DEPTH {instr, pc, pc+4} entries so a decode stall does not freeze fetch.
//   A redirect (taken branch/jump) flushes the queue and reloads the PC.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-low reset (wins over every other input)
//   fq     - fetch_queue_if.slave bundle (fetch request, imem read, decode head)
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic [XLEN-1:0] epc_q   [DEPTH];
    logic [XLEN-1:0] epc_d   [DEPTH];

    logic valid;
    logic full;
    logic pop;
    logic push;

    assign valid = (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));

    // Pop only a valid head; push into a full queue only when the head leaves
    // in the same cycle. Redirect suppresses the push of the wrong-path word.
    assign pop  = valid & ~fq.dec_stall;
    assign push = fq.fetch_en & ~fq.redirect & (~full | pop);

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        epc_d    = epc_q;

        if (fq.redirect) begin
            // Flush: the head and the in-flight imem word are both discarded.
            pc_d     = fq.redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = fq.imem_rdata;
                epc_d[wr_ptr_q]   = pc_q;
                wr_ptr_d          = wr_ptr_q + PW'(1);
                pc_d              = pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                epc_q[i]   <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            epc_q    <= epc_d;
        end
    end

    // Show-ahead head; the pc+4 field is derived from the stored pc.
    assign fq.imem_addr   = pc_q;
    assign fq.dec_valid   = valid;
    assign fq.dec_instr   = valid ? instr_q[rd_ptr_q] : NOP;
    assign fq.dec_pc      = valid ? epc_q[rd_ptr_q] : '0;
    assign fq.dec_pcplus4 = valid ? (epc_q[rd_ptr_q] + XLEN'(4)) : '0;
    assign fq.count       = count_q;
    assign fq.full        = full;
    assign fq.empty       = ~valid;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random stimulus for fetch_queue, checked each cycle
// against a queue-based reference model of the fetch queue behaviour.
module tb_fetch_queue;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOPI  = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ent_t        mq[$];
    logic [31:0] mpc;

    fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_PC(RPC),
        .NOP(NOPI)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .fq(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        bit v;
        v = (mq.size() != 0);
        chk("imem_addr",   64'(bus.imem_addr),   64'(mpc));
        chk("dec_valid",   64'(bus.dec_valid),   64'(v));
        chk("dec_instr",   64'(bus.dec_instr),   v ? 64'(mq[0].instr) : 64'(NOPI));
        chk("dec_pc",      64'(bus.dec_pc),      v ? 64'(mq[0].pc) : 64'(0));
        chk("dec_pcplus4", 64'(bus.dec_pcplus4), v ? 64'(32'(mq[0].pc + 32'd4)) : 64'(0));
        chk("count",       64'(bus.count),       64'(mq.size()));
        chk("full",        64'(bus.full),        64'(mq.size() == DEPTH));
        chk("empty",       64'(bus.empty),       64'(mq.size() == 0));
    endtask

    // One clock: fresh imem word, compare current outputs, advance the model.
    task automatic cycle(input bit do_chk);
        bit pop, push;
        bus.imem_rdata = $urandom;
        #1;
        if (do_chk) compare_all();
        if (!rst_n) begin
            mq.delete();
            mpc = RPC;
        end else if (bus.redirect) begin
            mq.delete();
            mpc = bus.redirect_pc;
        end else begin
            pop  = (mq.size() != 0) && !bus.dec_stall;
            push = bus.fetch_en && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{instr: bus.imem_rdata, pc: mpc});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fill_exp [6] = '{1, 2, 3, 4, 4, 4};
        mpc = RPC;
        rst_n = 1'b0;
        bus.fetch_en = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_stall = 1'b0;
        bus.imem_rdata = '0;

        // Reset for two cycles (DUT state unknown before the first edge).
        cycle(1'b0);
        cycle(1'b1);
        rst_n = 1'b1;
        #1;
        chk("rst_imem_addr", 64'(bus.imem_addr), 64'(RPC));
        chk("rst_empty",     64'(bus.empty),     64'd1);
        chk("rst_dec_instr", 64'(bus.dec_instr), 64'h13);
        chk("rst_dec_valid", 64'(bus.dec_valid), 64'd0);

        // Fill with decode stalled.
        bus.fetch_en = 1'b1;
        bus.dec_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1);
            chk("fill_count", 64'(bus.count), 64'(fill_exp[i]));
        end
        chk("fill_full",      64'(bus.full),        64'd1);
        chk("fill_imem_addr", 64'(bus.imem_addr),   64'h10);
        chk("fill_head_pc",   64'(bus.dec_pc),      64'h0);
        chk("fill_head_pc4",  64'(bus.dec_pcplus4), 64'h4);

        // Full-rate drain and refill: no bubbles.
        bus.dec_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("thru_dec_pc", 64'(bus.dec_pc), 64'(32'(4 * i)));
            chk("thru_count",  64'(bus.count),  64'd4);
            cycle(1'b1);
        end

        // Redirect while full.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        cycle(1'b1);
        bus.redirect = 1'b0;
        #1;
        chk("redir_count",     64'(bus.count),     64'd0);
        chk("redir_imem_addr", 64'(bus.imem_addr), 64'h100);
        chk("redir_valid",     64'(bus.dec_valid), 64'd0);
        cycle(1'b1);
        chk("redir_dec_pc", 64'(bus.dec_pc), 64'h100);
        chk("redir_count1", 64'(bus.count),  64'd1);

        // PC wrap at the top of the address space, then pointer wrap.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        cycle(1'b1);
        bus.redirect = 1'b0;
        bus.dec_stall = 1'b1;
        cycle(1'b1);
        chk("wrap_dec_pc",    64'(bus.dec_pc),      64'hFFFF_FFFC);
        chk("wrap_dec_pc4",   64'(bus.dec_pcplus4), 64'h0);
        chk("wrap_imem_addr", 64'(bus.imem_addr),   64'h0);
        bus.dec_stall = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1'b1);

        // Reset mid-operation beats a simultaneous redirect.
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        cycle(1'b1);
        bus.redirect = 1'b0;
        bus.dec_stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1);
        chk("mid_count3", 64'(bus.count), 64'd3);
        rst_n = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h300;
        cycle(1'b1);
        rst_n = 1'b1;
        bus.redirect = 1'b0;
        bus.fetch_en = 1'b0;
        #1;
        chk("mid_rst_count", 64'(bus.count),     64'd0);
        chk("mid_rst_addr",  64'(bus.imem_addr), 64'(RPC));

        // Random traffic including redirects, drains and occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n           = ($urandom_range(63) != 0);
            bus.redirect    = ($urandom_range(7) == 0);
            bus.redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : $urandom;
            bus.fetch_en    = ($urandom_range(3) != 0);
            bus.dec_stall   = ($urandom_range(2) == 0);
            cycle(1'b1);
        end
        rst_n = 1'b1;
        bus.redirect = 1'b0;
        #1;
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
